// File: rtl/button_conditioner.sv
// button_conditioner: 2-FF sync and counter debounce for LoadB/Run with press pulses; AUTOREPEAT_EN enables Run auto-repeat
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_CYCLES   = 25_000_000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        LoadB_raw,
    input  logic        Run_raw,
    input  logic [15:0] SW_raw,
    output logic        LoadB,
    output logic        Run,
    output logic        LoadB_pulse,
    output logic        Run_pulse,
    output logic [15:0] SW_sync
);
    localparam int CNT_W = $clog2(((DEBOUNCE_CYCLES > REPEAT_CYCLES) ? DEBOUNCE_CYCLES : REPEAT_CYCLES) + 1);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {REL, PPEND, HELD, RPEND} state_t;

    logic [1:0]  btn_s1, btn_s2;
    logic [15:0] sw_s1;

    // Two-stage synchronisers; buttons idle high (released), switches idle low
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            btn_s1  <= 2'b11;
            btn_s2  <= 2'b11;
            sw_s1   <= '0;
            SW_sync <= '0;
        end else begin
            btn_s1  <= {Run_raw, LoadB_raw};
            btn_s2  <= btn_s1;
            sw_s1   <= SW_raw;
            SW_sync <= sw_s1;
        end
    end

    // Bit 0 is LoadB, bit 1 is Run; each button gets its own independent debouncer
    for (genvar b = 0; b < 2; b++) begin : g_btn
        state_t           state;
        logic [CNT_W-1:0] cnt;
        logic             level, pulse, rep_hit, sync;

        assign sync = btn_s2[b];

`ifdef AUTOREPEAT_EN
        if (b == 1) begin : g_rep
            localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);
            logic [CNT_W-1:0] rcnt;
            // Repeat timer counts only while staying in HELD, restarting on every HELD entry
            always_ff @(posedge Clk) begin
                if (!Reset || state != HELD || sync)
                    rcnt <= '0;
                else
                    rcnt <= (rcnt == REP_LAST) ? '0 : rcnt + 1'b1;
            end
            assign rep_hit = (state == HELD) && (rcnt == REP_LAST);
        end else begin : g_norep
            assign rep_hit = 1'b0;
        end
`else
        assign rep_hit = 1'b0;
`endif

        // Press/release qualification FSM with registered level and one-cycle pulse
        always_ff @(posedge Clk) begin
            if (!Reset) begin
                state <= REL;
                cnt   <= '0;
                level <= 1'b1;
                pulse <= 1'b0;
            end else begin
                pulse <= 1'b0;
                case (state)
                    REL: begin
                        if (!sync) begin
                            state <= PPEND;
                            cnt   <= '0;
                        end
                    end
                    PPEND: begin
                        if (sync) begin
                            state <= REL;
                            cnt   <= '0;
                        end else if (cnt == DEB_LAST) begin
                            state <= HELD;
                            cnt   <= '0;
                            level <= 1'b0;
                            pulse <= 1'b1;
                        end else
                            cnt <= cnt + 1'b1;
                    end
                    HELD: begin
                        if (sync) begin
                            state <= RPEND;
                            cnt   <= '0;
                        end else if (rep_hit)
                            pulse <= 1'b1;
                    end
                    RPEND: begin
                        if (!sync) begin
                            state <= HELD;
                            cnt   <= '0;
                        end else if (cnt == DEB_LAST) begin
                            state <= REL;
                            cnt   <= '0;
                            level <= 1'b1;
                        end else
                            cnt <= cnt + 1'b1;
                    end
                endcase
            end
        end
    end

    assign LoadB       = g_btn[0].level;
    assign Run         = g_btn[1].level;
    assign LoadB_pulse = g_btn[0].pulse;
    assign Run_pulse   = g_btn[1].pulse;
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed stimulus with a run-length reference model checked every cycle
module tb_button_conditioner;
    localparam int D = 4;
    localparam int R = 8;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        LoadB_raw = 1'b1;
    logic        Run_raw = 1'b0;
    logic [15:0] SW_raw = 16'hFFFF;
    logic        LoadB, Run, LoadB_pulse, Run_pulse;
    logic [15:0] SW_sync;

    int total = 0;
    int bad = 0;
    int n_lp = 0;
    int n_rp = 0;

    button_conditioner #(.DEBOUNCE_CYCLES(D), .REPEAT_CYCLES(R)) dut (
        .Clk(Clk), .Reset(Reset), .LoadB_raw(LoadB_raw), .Run_raw(Run_raw), .SW_raw(SW_raw),
        .LoadB(LoadB), .Run(Run), .LoadB_pulse(LoadB_pulse), .Run_pulse(Run_pulse), .SW_sync(SW_sync)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance n falling edges, tallying the pulses seen on the way
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge Clk);
            n_lp += int'(LoadB_pulse);
            n_rp += int'(Run_pulse);
        end
    endtask

    // Reference model: level flips once the synchronised input has disagreed with it for D+1 samples in a row
    logic [1:0]  m_s1, m_s2, m_lvl, m_pulse, m_was_held;
    logic [15:0] m_sw1, m_sw2;
    logic        m_held;
    int          m_run [2];
    int          m_age;
    bit          started = 0;

    always @(posedge Clk) begin
        if (!Reset) begin
            m_s1 = 2'b11; m_s2 = 2'b11; m_lvl = 2'b11; m_pulse = 2'b00; m_was_held = 2'b00;
            m_sw1 = '0; m_sw2 = '0; m_run = '{0, 0}; m_age = 0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                m_pulse[b] = 1'b0;
                m_run[b] = (m_s2[b] != m_lvl[b]) ? m_run[b] + 1 : 0;
                if (m_run[b] == D + 1) begin
                    m_lvl[b] = ~m_lvl[b];
                    m_run[b] = 0;
                    m_pulse[b] = ~m_lvl[b];
                end
                m_held = !m_lvl[b] && m_run[b] == 0;
`ifdef AUTOREPEAT_EN
                if (b == 1) begin
                    if (m_held && m_was_held[b]) begin
                        m_age++;
                        if (m_age == R) begin
                            m_age = 0;
                            m_pulse[b] = 1'b1;
                        end
                    end else
                        m_age = 0;
                end
`endif
                m_was_held[b] = m_held;
            end
            m_s2 = m_s1; m_s1 = {Run_raw, LoadB_raw};
            m_sw2 = m_sw1; m_sw1 = SW_raw;
        end
        started = 1;
    end

    always @(negedge Clk) begin
        if (started) begin
            check("LoadB", LoadB, m_lvl[0]);
            check("Run", Run, m_lvl[1]);
            check("LoadB_pulse", LoadB_pulse, m_pulse[0]);
            check("Run_pulse", Run_pulse, m_pulse[1]);
            check("SW_sync", SW_sync, m_sw2);
        end
    end

    int got_off[$];
    int exp_off[$];

    initial begin
        // 1: reset with Run held, then release and re-qualify
        step(3);
        check("rst_LoadB", LoadB, 1);
        check("rst_Run", Run, 1);
        check("rst_LoadB_pulse", LoadB_pulse, 0);
        check("rst_Run_pulse", Run_pulse, 0);
        check("rst_SW_sync", SW_sync, 16'h0000);
        Reset = 1'b1;
        n_rp = 0;
        step(6);
        check("rel_run_early", Run, 1);
        check("rel_run_early_pulses", n_rp, 0);
        step(1);
        check("rel_run_level", Run, 0);
        check("rel_run_pulse", Run_pulse, 1);
        step(1);
        check("rel_run_pulse_gone", Run_pulse, 0);
        check("rel_run_pulse_count", n_rp, 1);
        Run_raw = 1'b1;
        step(12);

        // 2: clean LoadB press and release
        SW_raw = 16'h0F0F;
        LoadB_raw = 1'b0;
        n_lp = 0;
        step(6);
        check("lb_press_early", LoadB, 1);
        check("lb_press_early_pulses", n_lp, 0);
        step(1);
        check("lb_press_level", LoadB, 0);
        check("lb_press_pulse", LoadB_pulse, 1);
        step(1);
        check("lb_pulse_gone", LoadB_pulse, 0);
        step(22);
        check("lb_held_pulses", n_lp, 1);
        LoadB_raw = 1'b1;
        step(6);
        check("lb_release_early", LoadB, 0);
        step(1);
        check("lb_release_level", LoadB, 1);
        check("lb_release_no_pulse", n_lp, 1);
        step(5);

        // 3: bouncy Run press, then a short glitch while held
        n_rp = 0;
        Run_raw = 1'b0; step(2);
        Run_raw = 1'b1; step(2);
        Run_raw = 1'b0; step(2);
        Run_raw = 1'b1; step(2);
        Run_raw = 1'b0;
        step(6);
        check("bounce_no_early_pulse", n_rp, 0);
        check("bounce_level_early", Run, 1);
        step(1);
        check("bounce_pulse", Run_pulse, 1);
        check("bounce_level", Run, 0);
        Run_raw = 1'b1; step(2);
        Run_raw = 1'b0; step(8);
        check("glitch_level", Run, 0);
        check("glitch_one_pulse", n_rp, 1);
        Run_raw = 1'b1;
        step(12);

        // 4: simultaneous presses and switch pass-through
        LoadB_raw = 1'b0;
        Run_raw = 1'b0;
        SW_raw = 16'hA5C3;
        step(1);
        check("sw_one_cycle", SW_sync, 16'h0F0F);
        step(1);
        check("sw_two_cycles", SW_sync, 16'hA5C3);
        step(5);
        check("both_lb_pulse", LoadB_pulse, 1);
        check("both_run_pulse", Run_pulse, 1);
        LoadB_raw = 1'b1;
        Run_raw = 1'b1;
        step(12);

        // 5: reset in the middle of press qualification
        Run_raw = 1'b0;
        n_rp = 0;
        step(5);
        Reset = 1'b0;
        step(2);
        check("midrst_level", Run, 1);
        check("midrst_no_pulse", n_rp, 0);
        Reset = 1'b1;
        step(6);
        check("midrst_early", n_rp, 0);
        step(1);
        check("midrst_pulse", Run_pulse, 1);

        // 6: Run held after qualifying; repeats only with AUTOREPEAT_EN
        n_rp = 0;
        for (int k = 1; k <= 30; k++) begin
            step(1);
            if (Run_pulse) got_off.push_back(k);
        end
`ifdef AUTOREPEAT_EN
        exp_off = '{8, 16, 24};
`endif
        check("repeat_count", got_off.size(), exp_off.size());
        for (int i = 0; i < exp_off.size() && i < got_off.size(); i++)
            check("repeat_offset", got_off[i], exp_off[i]);
        check("repeat_level", Run, 0);
        Run_raw = 1'b1;
        step(12);
        check("final_release", Run, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
